// File: rtl/arbitro_memoria_dados.sv
// Data-memory arbiter between the nRisc core and one auxiliary port.
// The core has priority; the aux port is granted after MAX_WAIT consecutive denied cycles.
module arbitro_memoria_dados #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   // core side
   input  logic              i_cpu_mem_read,
   input  logic              i_cpu_mem_write,
   input  logic [ADDR_W-1:0] i_cpu_endereco,
   input  logic [DATA_W-1:0] i_cpu_dado_escr,
   output logic [DATA_W-1:0] o_cpu_dado_lido,
   output logic              o_cpu_stall,
   // auxiliary side
   input  logic              i_aux_req,
   input  logic              i_aux_we,
   input  logic [ADDR_W-1:0] i_aux_endereco,
   input  logic [DATA_W-1:0] i_aux_dado_escr,
   output logic              o_aux_gnt,
   output logic              o_aux_valid,
   output logic [DATA_W-1:0] o_aux_dado_lido,
   // memory side
   output logic [ADDR_W-1:0] o_mem_endereco,
   output logic [DATA_W-1:0] o_mem_dado_escr,
   output logic              o_mem_read,
   output logic              o_mem_write,
   input  logic [DATA_W-1:0] i_mem_dado_lido
);

   localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      OwnNone = 2'd0,
      OwnCpu  = 2'd1,
      OwnAux  = 2'd2
   } owner_e;

   owner_e            r_owner;
   owner_e            w_owner_nxt;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0]  w_wait_cnt_nxt;
   logic [DATA_W-1:0] r_cpu_dado;
   logic [DATA_W-1:0] r_aux_dado;

   logic w_cpu_req;
   logic w_cnt_full;
   logic w_aux_gnt;
   logic w_cpu_gnt;

   // Grant logic is gated by reset so every strobe drops the instant reset asserts.
   always_comb begin
      w_cpu_req  = i_cpu_mem_read | i_cpu_mem_write;
      w_cnt_full = (r_wait_cnt == CNT_W'(MAX_WAIT));
      w_aux_gnt  = i_rst_n & i_aux_req & (~w_cpu_req | w_cnt_full);
      w_cpu_gnt  = i_rst_n & w_cpu_req & ~w_aux_gnt;
   end

   always_comb begin
      o_aux_gnt       = w_aux_gnt;
      o_cpu_stall     = w_aux_gnt & w_cpu_req;
      o_mem_endereco  = '0;
      o_mem_dado_escr = '0;
      o_mem_read      = 1'b0;
      o_mem_write     = 1'b0;
      if (w_aux_gnt) begin
         o_mem_endereco  = i_aux_endereco;
         o_mem_dado_escr = i_aux_dado_escr;
         o_mem_read      = ~i_aux_we;
         o_mem_write     = i_aux_we;
      end else if (w_cpu_gnt) begin
         o_mem_endereco  = i_cpu_endereco;
         o_mem_dado_escr = i_cpu_dado_escr;
         o_mem_read      = i_cpu_mem_read;
         o_mem_write     = i_cpu_mem_write;
      end
   end

   // Starvation counter: counts consecutive denied aux cycles, saturating at MAX_WAIT.
   always_comb begin
      w_wait_cnt_nxt = '0;
      if (i_aux_req && !w_aux_gnt) begin
         w_wait_cnt_nxt = w_cnt_full ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wait_cnt <= '0;
      end else begin
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Read-owner FSM: remembers who issued the read whose data returns next cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner <= OwnNone;
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_owner_nxt = OwnNone;
      if (w_aux_gnt && !i_aux_we) begin
         w_owner_nxt = OwnAux;
      end else if (w_cpu_gnt && i_cpu_mem_read) begin
         w_owner_nxt = OwnCpu;
      end
   end

   // Hold registers keep the last returned word visible while the other side reads.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cpu_dado <= '0;
         r_aux_dado <= '0;
      end else begin
         if (r_owner == OwnCpu) begin
            r_cpu_dado <= i_mem_dado_lido;
         end
         if (r_owner == OwnAux) begin
            r_aux_dado <= i_mem_dado_lido;
         end
      end
   end

   always_comb begin
      o_aux_valid     = (r_owner == OwnAux);
      o_cpu_dado_lido = (r_owner == OwnCpu) ? i_mem_dado_lido : r_cpu_dado;
      o_aux_dado_lido = (r_owner == OwnAux) ? i_mem_dado_lido : r_aux_dado;
   end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Scoreboard bench for arbitro_memoria_dados: directed scenarios then random traffic
// against a transaction-level reference model with its own copy of memory.
module tb_arbitro_memoria_dados;

   localparam int MAX_WAIT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cpu_rd, cpu_wr, aux_req, aux_we;
   logic [7:0] cpu_a, cpu_d, aux_a, aux_d;
   logic [7:0] cpu_lido, aux_lido, mem_a, mem_wd, mem_rd;
   logic       cpu_stall, aux_gnt, aux_valid, mem_read, mem_write;

   arbitro_memoria_dados #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_cpu_mem_read  (cpu_rd),
      .i_cpu_mem_write (cpu_wr),
      .i_cpu_endereco  (cpu_a),
      .i_cpu_dado_escr (cpu_d),
      .o_cpu_dado_lido (cpu_lido),
      .o_cpu_stall     (cpu_stall),
      .i_aux_req       (aux_req),
      .i_aux_we        (aux_we),
      .i_aux_endereco  (aux_a),
      .i_aux_dado_escr (aux_d),
      .o_aux_gnt       (aux_gnt),
      .o_aux_valid     (aux_valid),
      .o_aux_dado_lido (aux_lido),
      .o_mem_endereco  (mem_a),
      .o_mem_dado_escr (mem_wd),
      .o_mem_read      (mem_read),
      .o_mem_write     (mem_write),
      .i_mem_dado_lido (mem_rd)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int i);
      if (i == 8'h10) return 8'hA5;
      if (i == 8'h03) return 8'h3C;
      if (i == 8'h04) return 8'h4D;
      return 8'((i * 37 + 11) ^ 8'h5A);
   endfunction

   // Single-port synchronous memory: read data valid the cycle after MemRead.
   logic [7:0] tb_mem [256];
   logic       mem_init_done = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
         mem_init_done <= 1'b1;
      end else begin
         if (mem_write) tb_mem[mem_a] <= mem_wd;
         if (mem_read) mem_rd <= tb_mem[mem_a];
      end
   end

   typedef struct {
      int         tag;
      logic [7:0] data;
   } rd_exp_t;

   rd_exp_t    cpu_q[$];
   rd_exp_t    aux_q[$];
   logic [7:0] ref_mem [256];
   int         m_wait;
   int         cyc;
   int         n_cmp;
   int         n_err;
   logic       last_stall, last_agnt;
   logic [7:0] exp_cpu;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a read result is due.
   always @(negedge clk) begin
      if (!rst_n) begin
         cpu_q.delete();
         aux_q.delete();
         exp_cpu = 8'h00;
         check("aux_valid_in_reset", {31'd0, aux_valid}, 32'd0);
         check("cpu_lido_in_reset", {24'd0, cpu_lido}, 32'd0);
      end else if (mem_init_done) begin
         if (aux_q.size() > 0 && aux_q[0].tag == cyc) begin
            check("aux_valid", {31'd0, aux_valid}, 32'd1);
            check("aux_lido", {24'd0, aux_lido}, {24'd0, aux_q[0].data});
            void'(aux_q.pop_front());
         end else begin
            check("aux_valid_idle", {31'd0, aux_valid}, 32'd0);
         end
         if (cpu_q.size() > 0 && cpu_q[0].tag == cyc) begin
            exp_cpu = cpu_q[0].data;
            void'(cpu_q.pop_front());
         end
         check("cpu_lido", {24'd0, cpu_lido}, {24'd0, exp_cpu});
      end
   end

   task automatic drive_cycle(input logic crd, input logic cwr, input logic [7:0] ca,
                              input logic [7:0] cd, input logic areq, input logic awe,
                              input logic [7:0] aa, input logic [7:0] ad);
      logic       creq, a_win, c_win, e_rd, e_wr;
      logic [7:0] e_a, e_d;
      cpu_rd = crd; cpu_wr = cwr; cpu_a = ca; cpu_d = cd;
      aux_req = areq; aux_we = awe; aux_a = aa; aux_d = ad;
      #1;
      creq  = crd | cwr;
      a_win = areq && (!creq || m_wait == MAX_WAIT);
      c_win = creq && !a_win;
      e_rd = 1'b0; e_wr = 1'b0; e_a = 8'h00; e_d = 8'h00;
      if (a_win) begin
         e_rd = !awe; e_wr = awe; e_a = aa; e_d = ad;
      end else if (c_win) begin
         e_rd = crd; e_wr = cwr; e_a = ca; e_d = cd;
      end
      check("gnt_stall", {30'd0, aux_gnt, cpu_stall}, {30'd0, a_win, a_win && creq});
      check("mem_strobes", {30'd0, mem_read, mem_write}, {30'd0, e_rd, e_wr});
      if (e_rd || e_wr) check("mem_addr", {24'd0, mem_a}, {24'd0, e_a});
      if (e_wr) check("mem_wdata", {24'd0, mem_wd}, {24'd0, e_d});
      if (a_win) begin
         if (awe) ref_mem[aa] = ad;
         else aux_q.push_back('{tag: cyc + 1, data: ref_mem[aa]});
      end
      if (c_win) begin
         if (cwr) ref_mem[ca] = cd;
         if (crd) cpu_q.push_back('{tag: cyc + 1, data: ref_mem[ca]});
      end
      m_wait     = (areq && !a_win) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      last_stall = a_win && creq;
      last_agnt  = a_win;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_reset_outputs();
      check("rst_strobes", {27'd0, aux_gnt, cpu_stall, aux_valid, mem_read, mem_write}, 32'd0);
      check("rst_addr_data", {16'd0, mem_a, mem_wd}, 32'd0);
   endtask

   task automatic pulse_reset();
      rst_n  = 1'b0;
      m_wait = 0;
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
      cyc++;
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
   endtask

   logic       c_rd, c_wr, a_pend, a_we;
   logic [7:0] c_a, c_d, a_a, a_d;

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; m_wait = 0;
      last_stall = 1'b0; last_agnt = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      // Reset held with both sides requesting.
      cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_a = 8'h05; cpu_d = 8'h11;
      aux_req = 1'b1; aux_we = 1'b0; aux_a = 8'h10; aux_d = 8'h00;
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Core writes every cycle with aux held: aux wins on the fifth.
      for (int i = 0; i < MAX_WAIT + 2; i++)
         drive_cycle(1'b0, 1'b1, 8'h05 + 8'(i), 8'h11 + 8'(i), (i <= MAX_WAIT), 1'b0, 8'h10, 8'h00);
      // Aux read alone.
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      // Core read then aux read back-to-back.
      drive_cycle(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h04, 8'h00);
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      // Aux write under conflict, then core reads the same address.
      for (int i = 0; i <= MAX_WAIT; i++)
         drive_cycle(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b1, 8'h20, 8'h77);
      drive_cycle(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      check("cpu_reads_77", {24'd0, cpu_lido}, 32'h77);
      // Reset right after an aux read grant: no late AuxValid, counter cleared.
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      aux_req = 1'b0;
      pulse_reset();
      for (int i = 0; i < MAX_WAIT + 2; i++)
         drive_cycle(1'b1, 1'b0, 8'h01, 8'h00, (i <= MAX_WAIT), 1'b0, 8'h02, 8'h00);
      // Random traffic over a small address window to force collisions.
      c_rd = 1'b0; c_wr = 1'b0; c_a = 8'h00; c_d = 8'h00;
      a_pend = 1'b0; a_we = 1'b0; a_a = 8'h00; a_d = 8'h00;
      for (int n = 0; n < 600; n++) begin
         if (!last_stall) begin
            case ($urandom_range(0, 2))
               0: begin c_rd = 1'b0; c_wr = 1'b0; end
               1: begin c_rd = 1'b1; c_wr = 1'b0; end
               default: begin c_rd = 1'b0; c_wr = 1'b1; end
            endcase
            c_a = 8'($urandom_range(0, 15));
            c_d = 8'($urandom);
         end
         if (!a_pend && $urandom_range(0, 1) == 1) begin
            a_pend = 1'b1;
            a_we   = 1'($urandom);
            a_a    = 8'($urandom_range(0, 15));
            a_d    = 8'($urandom);
         end
         drive_cycle(c_rd, c_wr, c_a, c_d, a_pend, a_we, a_a, a_d);
         if (last_agnt) a_pend = 1'b0;
      end
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      check("aux_q_drained", aux_q.size(), 32'd0);
      check("cpu_q_drained", cpu_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
